// File: rtl/snoop_bus_arbiter.sv
// Two-core snooping bus arbiter: round-robin grant, snoop broadcast, optional
// dirty write-back and memory fill, then a one-cycle completion pulse.
module snoop_bus_arbiter #(
    parameter int unsigned SNOOP_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      bus_req,
    input  logic [1:0][1:0] bus_cmd,
    input  logic [1:0][7:0] bus_addr,
    output logic [1:0]      bus_gnt,
    output logic            snoop_valid,
    output logic [1:0]      snoop_cmd,
    output logic [7:0]      snoop_addr,
    input  logic            snoop_resp_valid,
    input  logic            snoop_hit,
    input  logic            snoop_dirty,
    output logic            mem_req,
    output logic            mem_we,
    output logic [7:0]      mem_addr,
    input  logic            mem_ack,
    output logic            bus_done,
    output logic            bus_shared
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CMD_W  = 2;
    localparam int unsigned CNT_W  = (SNOOP_TIMEOUT > 1) ? $clog2(SNOOP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SNOOP_TIMEOUT - 1);

    localparam logic [CMD_W-1:0] CMD_NONE = 2'b00;
    localparam logic [CMD_W-1:0] CMD_RD   = 2'b01;
    localparam logic [CMD_W-1:0] CMD_UPGR = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SNOOP = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_FILL  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hit_q, hit_d;
    logic              dirty_q, dirty_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        bus_gnt_q, bus_gnt_d;
    logic              snoop_valid_q, snoop_valid_d;
    logic [CMD_W-1:0]  snoop_cmd_q, snoop_cmd_d;
    logic [ADDR_W-1:0] snoop_addr_q, snoop_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              bus_done_q, bus_done_d;
    logic              bus_shared_q, bus_shared_d;

    logic [1:0]        req_v;
    logic              snoop_exit;

    assign req_v[0] = bus_req[0] && (bus_cmd[0] != CMD_NONE);
    assign req_v[1] = bus_req[1] && (bus_cmd[1] != CMD_NONE);

    // Next state plus the registered view of the outputs for that next state.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        hit_d        = hit_q;
        dirty_d      = dirty_q;
        cnt_d        = cnt_q;
        snoop_exit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_v != 2'b00) begin
                    if (req_v == 2'b11) begin
                        owner_d = ~last_owner_q;
                    end else begin
                        owner_d = req_v[1];
                    end
                    cmd_d   = bus_cmd[owner_d];
                    addr_d  = bus_addr[owner_d];
                    hit_d   = 1'b0;
                    dirty_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                if (snoop_resp_valid) begin
                    hit_d      = snoop_hit;
                    dirty_d    = snoop_dirty;
                    snoop_exit = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    hit_d      = 1'b0;
                    dirty_d    = 1'b0;
                    snoop_exit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (snoop_exit) begin
                    if (dirty_d) begin
                        state_d = ST_FLUSH;
                    end else if (cmd_q == CMD_UPGR) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FLUSH: begin
                if (mem_ack) begin
                    state_d = (cmd_q == CMD_UPGR) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        bus_gnt_d     = (state_d == ST_IDLE) ? 2'b00 : (owner_d ? 2'b10 : 2'b01);
        snoop_valid_d = (state_d == ST_SNOOP);
        snoop_cmd_d   = snoop_valid_d ? cmd_d : CMD_NONE;
        snoop_addr_d  = snoop_valid_d ? addr_d : '0;
        mem_req_d     = (state_d == ST_FLUSH) || (state_d == ST_FILL);
        mem_we_d      = (state_d == ST_FLUSH);
        mem_addr_d    = mem_req_d ? addr_d : '0;
        bus_done_d    = (state_d == ST_DONE);
        bus_shared_d  = bus_done_d && hit_d && (cmd_d == CMD_RD);
    end

    // Synchronous reset aborts any transaction outright; core 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;
            cmd_q         <= CMD_NONE;
            addr_q        <= '0;
            hit_q         <= 1'b0;
            dirty_q       <= 1'b0;
            cnt_q         <= '0;
            bus_gnt_q     <= 2'b00;
            snoop_valid_q <= 1'b0;
            snoop_cmd_q   <= CMD_NONE;
            snoop_addr_q  <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            bus_done_q    <= 1'b0;
            bus_shared_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            hit_q         <= hit_d;
            dirty_q       <= dirty_d;
            cnt_q         <= cnt_d;
            bus_gnt_q     <= bus_gnt_d;
            snoop_valid_q <= snoop_valid_d;
            snoop_cmd_q   <= snoop_cmd_d;
            snoop_addr_q  <= snoop_addr_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            bus_done_q    <= bus_done_d;
            bus_shared_q  <= bus_shared_d;
        end
    end

    assign bus_gnt     = bus_gnt_q;
    assign snoop_valid = snoop_valid_q;
    assign snoop_cmd   = snoop_cmd_q;
    assign snoop_addr  = snoop_addr_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign bus_done    = bus_done_q;
    assign bus_shared  = bus_shared_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed and random checks of snoop_bus_arbiter with a grant/done scoreboard.
module tb_snoop_bus_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      bus_req;
    logic [1:0][1:0] bus_cmd;
    logic [1:0][7:0] bus_addr;
    logic [1:0]      bus_gnt;
    logic            snoop_valid;
    logic [1:0]      snoop_cmd;
    logic [7:0]      snoop_addr;
    logic            snoop_resp_valid;
    logic            snoop_hit;
    logic            snoop_dirty;
    logic            mem_req;
    logic            mem_we;
    logic [7:0]      mem_addr;
    logic            mem_ack;
    logic            bus_done;
    logic            bus_shared;

    typedef struct packed {
        logic owner;
        logic shared;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    logic model_last = 1'b1;
    logic plan_hit = 1'b0;
    logic [1:0] prev_gnt = 2'b00;
    logic prev_done = 1'b0;

    snoop_bus_arbiter #(.SNOOP_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_gnt(bus_gnt),
        .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
        .snoop_resp_valid(snoop_resp_valid), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .bus_done(bus_done), .bus_shared(bus_shared)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},        32'(bus_gnt),     32'h0);
        chk({tag, "_snoop_v"},    32'(snoop_valid), 32'h0);
        chk({tag, "_snoop_cmd"},  32'(snoop_cmd),   32'h0);
        chk({tag, "_snoop_addr"}, 32'(snoop_addr),  32'h0);
        chk({tag, "_mem_req"},    32'(mem_req),     32'h0);
        chk({tag, "_mem_we"},     32'(mem_we),      32'h0);
        chk({tag, "_mem_addr"},   32'(mem_addr),    32'h0);
        chk({tag, "_done"},       32'(bus_done),    32'h0);
        chk({tag, "_shared"},     32'(bus_shared),  32'h0);
    endtask

    // One clock: predict arbitration from the driven inputs, push/pop the scoreboard.
    task automatic tick();
        logic            rst_s;
        logic [1:0]      req_s;
        logic [1:0][1:0] cmd_s;
        logic [1:0][7:0] addr_s;
        logic [1:0]      v;
        logic            own;
        exp_t            e;
        rst_s  = rst;
        req_s  = bus_req;
        cmd_s  = bus_cmd;
        addr_s = bus_addr;
        @(posedge clk);
        #1;
        chk("gnt_not_both", 32'(bus_gnt != 2'b11), 32'h1);
        if (rst_s) begin
            sb.delete();
            model_last = 1'b1;
            prev_gnt   = 2'b00;
            prev_done  = 1'b0;
            return;
        end
        if (prev_done) chk("idle_after_done", 32'(bus_gnt), 32'h0);
        if (prev_gnt == 2'b00) begin
            v[0] = req_s[0] && (cmd_s[0] != 2'b00);
            v[1] = req_s[1] && (cmd_s[1] != 2'b00);
            if (v == 2'b00) begin
                chk("no_grant", 32'(bus_gnt), 32'h0);
            end else begin
                own = (v == 2'b11) ? ~model_last : v[1];
                chk("grant",       32'(bus_gnt),     own ? 32'h2 : 32'h1);
                chk("snoop_valid", 32'(snoop_valid), 32'h1);
                chk("snoop_addr",  32'(snoop_addr),  32'(addr_s[own]));
                chk("snoop_cmd",   32'(snoop_cmd),   32'(cmd_s[own]));
                e.owner  = own;
                e.shared = plan_hit && (cmd_s[own] == 2'b01);
                sb.push_back(e);
            end
        end
        if (bus_done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(bus_done), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("done_gnt",    32'(bus_gnt),    e.owner ? 32'h2 : 32'h1);
                chk("done_shared", 32'(bus_shared), 32'(e.shared));
                model_last = e.owner;
                n_done++;
            end
        end
        prev_gnt  = bus_gnt;
        prev_done = bus_done;
    endtask

    task automatic run_done(input int budget);
        int start;
        int k;
        start = n_done;
        k = 0;
        while (n_done == start && k < budget) begin
            tick();
            k++;
        end
        chk("done_timeout", 32'(n_done - start), 32'h1);
    endtask

    initial begin
        int sv;
        int mr;
        int k;
        rst = 1'b1;
        bus_req = '0;
        bus_cmd = '0;
        bus_addr = '0;
        snoop_resp_valid = 1'b0;
        snoop_hit = 1'b0;
        snoop_dirty = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Core0 BusRd 0xAA, clean hit, fill acked two cycles after the snoop response.
        plan_hit = 1'b1;
        bus_req = 2'b01; bus_cmd[0] = 2'b01; bus_addr[0] = 8'hAA;
        tick();
        bus_req = 2'b00; bus_addr[0] = 8'h11;
        snoop_resp_valid = 1'b1; snoop_hit = 1'b1; snoop_dirty = 1'b0;
        tick();
        snoop_resp_valid = 1'b0;
        chk("rd_fill_req",  32'(mem_req),     32'h1);
        chk("rd_fill_we",   32'(mem_we),      32'h0);
        chk("rd_fill_addr", 32'(mem_addr),    32'hAA);
        chk("rd_snoop_off", 32'(snoop_valid), 32'h0);
        tick();
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rd_done",     32'(bus_done), 32'h1);
        chk("rd_done_mem", 32'(mem_req),  32'h0);
        tick();
        plan_hit = 1'b0;

        // Tie after reset: core0, then core1, then core0 again.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_req = 2'b11; bus_cmd[0] = 2'b10; bus_cmd[1] = 2'b10;
        bus_addr[0] = 8'hAA; bus_addr[1] = 8'hAA;
        snoop_resp_valid = 1'b1; snoop_hit = 1'b0; snoop_dirty = 1'b0; mem_ack = 1'b1;
        tick();
        chk("tie1_gnt", 32'(bus_gnt), 32'h1);
        run_done(10);
        tick();
        chk("tie_idle1", 32'(bus_gnt), 32'h0);
        tick();
        chk("tie2_gnt", 32'(bus_gnt), 32'h2);
        run_done(10);
        tick();
        tick();
        chk("tie3_gnt", 32'(bus_gnt), 32'h1);
        bus_req = 2'b00;
        run_done(10);
        tick();

        // Core1 BusRdX 0x3C with a dirty hit: write-back then fill.
        plan_hit = 1'b1;
        snoop_resp_valid = 1'b1; snoop_hit = 1'b1; snoop_dirty = 1'b1; mem_ack = 1'b0;
        bus_req = 2'b10; bus_cmd[1] = 2'b10; bus_addr[1] = 8'h3C;
        tick();
        bus_req = 2'b00;
        tick();
        snoop_resp_valid = 1'b0;
        chk("wb_req",  32'(mem_req),  32'h1);
        chk("wb_we",   32'(mem_we),   32'h1);
        chk("wb_addr", 32'(mem_addr), 32'h3C);
        tick();
        chk("wb_hold_we", 32'(mem_we), 32'h1);
        mem_ack = 1'b1;
        tick();
        chk("wbf_req",  32'(mem_req),  32'h1);
        chk("wbf_we",   32'(mem_we),   32'h0);
        chk("wbf_addr", 32'(mem_addr), 32'h3C);
        tick();
        mem_ack = 1'b0;
        chk("wb_done",   32'(bus_done),   32'h1);
        chk("wb_shared", 32'(bus_shared), 32'h0);
        tick();
        plan_hit = 1'b0;

        // Core0 BusUpgr 0x10 with no snoop response: timeout, straight to done.
        snoop_resp_valid = 1'b0; snoop_hit = 1'b0; snoop_dirty = 1'b0;
        bus_req = 2'b01; bus_cmd[0] = 2'b11; bus_addr[0] = 8'h10;
        tick();
        bus_req = 2'b00;
        sv = 32'(snoop_valid);
        mr = 32'(mem_req);
        k = 0;
        while (!bus_done && k < 20) begin
            tick();
            sv += 32'(snoop_valid);
            mr += 32'(mem_req);
            k++;
        end
        chk("upg_snoop_cycles", 32'(sv), 32'h8);
        chk("upg_mem_cycles",   32'(mr), 32'h0);
        chk("upg_done",         32'(bus_done),   32'h1);
        chk("upg_shared",       32'(bus_shared), 32'h0);
        tick();

        // Reset during FILL aborts; the held request is then served normally.
        snoop_resp_valid = 1'b1; snoop_hit = 1'b0; snoop_dirty = 1'b0; mem_ack = 1'b0;
        bus_req = 2'b01; bus_cmd[0] = 2'b01; bus_addr[0] = 8'h55;
        tick();
        tick();
        chk("abort_fill_req", 32'(mem_req), 32'h1);
        chk("abort_fill_we",  32'(mem_we),  32'h0);
        rst = 1'b1;
        tick();
        check_reset_outputs("abort");
        rst = 1'b0;
        mem_ack = 1'b1;
        tick();
        chk("post_abort_gnt", 32'(bus_gnt), 32'h1);
        bus_req = 2'b00;
        run_done(10);
        tick();

        // Random traffic; the per-tick checks cover grants, dones and mutual exclusion.
        snoop_hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            bus_req          = 2'($urandom_range(0, 3));
            bus_cmd[0]       = 2'($urandom_range(0, 3));
            bus_cmd[1]       = 2'($urandom_range(0, 3));
            bus_addr[0]      = 8'($urandom_range(0, 255));
            bus_addr[1]      = 8'($urandom_range(0, 255));
            snoop_resp_valid = ($urandom_range(0, 3) != 0);
            snoop_dirty      = 1'($urandom_range(0, 1));
            mem_ack          = 1'($urandom_range(0, 1));
            tick();
        end
        bus_req = 2'b00;
        snoop_resp_valid = 1'b1;
        snoop_dirty = 1'b0;
        mem_ack = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        tick();
        chk("sb_drained", 32'(sb.size()), 32'h0);
        chk("final_idle", 32'(bus_gnt),   32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
